// File: rtl/traffic_pkg.sv
// Shared definitions for the N-road occupancy counter: width helpers,
// default congestion thresholds and the per-road event type.
package traffic_pkg;

  localparam int unsigned CONG_HI_DEFAULT = 20;
  localparam int unsigned CONG_LO_DEFAULT = 12;

  typedef struct packed {
    logic inc;
    logic dec;
  } road_evt_t;

  function automatic int unsigned idx_width(input int unsigned num_roads);
    return (num_roads > 1) ? $clog2(num_roads) : 1;
  endfunction

  // The junction total needs log2(roads) extra bits so it can never wrap.
  function automatic int unsigned total_width(input int unsigned num_roads,
                                              input int unsigned count_w);
    return count_w + idx_width(num_roads);
  endfunction

endpackage

// File: rtl/traffic_counter_array_if.sv
// Sensor inputs and occupancy outputs of traffic_counter_array.
// master = sensor/consumer side, slave = the counter array.
interface traffic_counter_array_if
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_ROADS = 4,
  parameter int unsigned COUNT_W   = 8
);
  localparam int unsigned IDX_W   = idx_width(NUM_ROADS);
  localparam int unsigned TOTAL_W = total_width(NUM_ROADS, COUNT_W);

  // No handshake: pir_* are free-running async levels, outputs are registered
  // status that is valid every cycle after reset.
  logic [NUM_ROADS-1:0]         pir_start;
  logic [NUM_ROADS-1:0]         pir_end;
  logic [NUM_ROADS*COUNT_W-1:0] count;
  logic [NUM_ROADS-1:0]         congested;
  logic [NUM_ROADS-1:0]         ovf_err;
  logic [NUM_ROADS-1:0]         unf_err;
  logic [IDX_W-1:0]             busiest_idx;
  logic [COUNT_W-1:0]           busiest_count;
  logic [TOTAL_W-1:0]           total_count;

  modport master (
    output pir_start, pir_end,
    input  count, congested, ovf_err, unf_err,
    input  busiest_idx, busiest_count, total_count
  );

  modport slave (
    input  pir_start, pir_end,
    output count, congested, ovf_err, unf_err,
    output busiest_idx, busiest_count, total_count
  );

endinterface

// File: rtl/traffic_road_counter.sv
// One road: PIR synchronisers, rising-edge detect, saturating occupancy count,
// sticky error flags and congestion flag (hysteresis under TRAFFIC_CONG_HYST_EN).
module traffic_road_counter
  import traffic_pkg::*;
#(
  parameter int unsigned COUNT_W = 8,
  parameter int unsigned CONG_HI = CONG_HI_DEFAULT,
  parameter int unsigned CONG_LO = CONG_LO_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pir_start,
  input  logic               pir_end,
  output logic [COUNT_W-1:0] count,
  output logic               congested,
  output logic               ovf_err,
  output logic               unf_err
);

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  // Bit 0 carries the start sensor, bit 1 the end sensor.
  logic [1:0] pir_meta_q, pir_meta_d;
  logic [1:0] pir_sync_q, pir_sync_d;
  logic [1:0] pir_prev_q, pir_prev_d;

  logic [COUNT_W-1:0] count_q, count_d;
  logic               cong_q, cong_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  road_evt_t   evt;
  logic [31:0] count_ext;

  always_comb begin
    pir_meta_d = {pir_end, pir_start};
    pir_sync_d = pir_meta_q;
    pir_prev_d = pir_sync_q;

    evt.inc = pir_sync_q[0] & ~pir_prev_q[0];
    evt.dec = pir_sync_q[1] & ~pir_prev_q[1];

    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    // Coincident inc and dec cancel out, even at the saturation limits.
    case ({evt.inc, evt.dec})
      2'b10: begin
        if (count_q == CNT_MAX) ovf_d = 1'b1;
        else                    count_d = count_q + 1'b1;
      end
      2'b01: begin
        if (count_q == '0) unf_d = 1'b1;
        else               count_d = count_q - 1'b1;
      end
      default: ;
    endcase

    count_ext = 32'(count_d);
`ifdef TRAFFIC_CONG_HYST_EN
    cong_d = cong_q;
    if (count_ext >= CONG_HI)      cong_d = 1'b1;
    else if (count_ext <= CONG_LO) cong_d = 1'b0;
`else
    cong_d = (count_ext >= CONG_HI);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pir_meta_q <= '0;
      pir_sync_q <= '0;
      pir_prev_q <= '0;
      count_q    <= '0;
      cong_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      pir_meta_q <= pir_meta_d;
      pir_sync_q <= pir_sync_d;
      pir_prev_q <= pir_prev_d;
      count_q    <= count_d;
      cong_q     <= cong_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign count     = count_q;
  assign congested = cong_q;
  assign ovf_err   = ovf_q;
  assign unf_err   = unf_q;

endmodule

// File: rtl/traffic_counter_array.sv
// N-road vehicle occupancy counter with busiest-road scan and junction total.
// Optional congestion hysteresis: define TRAFFIC_CONG_HYST_EN.
module traffic_counter_array
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_ROADS = 4,
  parameter int unsigned COUNT_W   = 8,
  parameter int unsigned CONG_HI   = CONG_HI_DEFAULT,
  parameter int unsigned CONG_LO   = CONG_LO_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  traffic_counter_array_if.slave   bus
);

  localparam int unsigned IDX_W   = idx_width(NUM_ROADS);
  localparam int unsigned TOTAL_W = total_width(NUM_ROADS, COUNT_W);

  logic [COUNT_W-1:0]   road_cnt [NUM_ROADS];
  logic [NUM_ROADS-1:0] road_cong;
  logic [NUM_ROADS-1:0] road_ovf;
  logic [NUM_ROADS-1:0] road_unf;

  logic [IDX_W-1:0]   busiest_idx_q, busiest_idx_d;
  logic [COUNT_W-1:0] busiest_cnt_q, busiest_cnt_d;
  logic [TOTAL_W-1:0] total_q, total_d;

  for (genvar i = 0; i < NUM_ROADS; i++) begin : g_road
    traffic_road_counter #(
      .COUNT_W (COUNT_W),
      .CONG_HI (CONG_HI),
      .CONG_LO (CONG_LO)
    ) u_road (
      .clk       (clk),
      .reset     (reset),
      .pir_start (bus.pir_start[i]),
      .pir_end   (bus.pir_end[i]),
      .count     (road_cnt[i]),
      .congested (road_cong[i]),
      .ovf_err   (road_ovf[i]),
      .unf_err   (road_unf[i])
    );

    assign bus.count[i*COUNT_W +: COUNT_W] = road_cnt[i];
  end

  // Strict '>' keeps the lowest index on ties; all-zero yields road 0.
  always_comb begin
    busiest_idx_d = '0;
    busiest_cnt_d = road_cnt[0];
    total_d       = '0;
    for (int i = 0; i < NUM_ROADS; i++) begin
      if (road_cnt[i] > busiest_cnt_d) begin
        busiest_cnt_d = road_cnt[i];
        busiest_idx_d = IDX_W'(i);
      end
      total_d = total_d + TOTAL_W'(road_cnt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busiest_idx_q <= '0;
      busiest_cnt_q <= '0;
      total_q       <= '0;
    end else begin
      busiest_idx_q <= busiest_idx_d;
      busiest_cnt_q <= busiest_cnt_d;
      total_q       <= total_d;
    end
  end

  assign bus.congested     = road_cong;
  assign bus.ovf_err       = road_ovf;
  assign bus.unf_err       = road_unf;
  assign bus.busiest_idx   = busiest_idx_q;
  assign bus.busiest_count = busiest_cnt_q;
  assign bus.total_count   = total_q;

endmodule

// File: tb/tb_traffic_counter_array.sv
// Bench for traffic_counter_array: sample-history reference model compared every
// cycle, plus directed pulse sequences with hand-computed expectations.
module tb_traffic_counter_array;
  import traffic_pkg::*;

  localparam int NR   = 4;
  localparam int CW   = 4;
  localparam int HI   = 10;
  localparam int LO   = 6;
  localparam int MAXC = 15;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  traffic_counter_array_if #(.NUM_ROADS(NR), .COUNT_W(CW)) bus ();

  traffic_counter_array #(
    .NUM_ROADS (NR),
    .COUNT_W   (CW),
    .CONG_HI   (HI),
    .CONG_LO   (LO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_cnt [NR];
  bit m_ovf [NR];
  bit m_unf [NR];
  bit m_cong [NR];
  int m_bidx, m_bcnt, m_total;
  // hs/he[i][k]: sensor level sampled k edges ago (k=0 is this edge)
  bit hs [NR][4];
  bit he [NR][4];

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NR; i++) begin
        m_cnt[i] = 0; m_ovf[i] = 0; m_unf[i] = 0; m_cong[i] = 0;
        for (int k = 0; k < 4; k++) begin hs[i][k] = 0; he[i][k] = 0; end
      end
      m_bidx = 0; m_bcnt = 0; m_total = 0;
    end else begin
      m_bidx = 0; m_total = 0;
      for (int i = 0; i < NR; i++) begin
        if (m_cnt[i] > m_cnt[m_bidx]) m_bidx = i;
        m_total += m_cnt[i];
      end
      m_bcnt = m_cnt[m_bidx];
      for (int i = 0; i < NR; i++) begin
        bit inc, dec;
        for (int k = 3; k > 0; k--) begin hs[i][k] = hs[i][k-1]; he[i][k] = he[i][k-1]; end
        hs[i][0] = bus.pir_start[i];
        he[i][0] = bus.pir_end[i];
        inc = hs[i][2] && !hs[i][3];
        dec = he[i][2] && !he[i][3];
        if (inc && !dec) begin
          if (m_cnt[i] == MAXC) m_ovf[i] = 1; else m_cnt[i]++;
        end else if (dec && !inc) begin
          if (m_cnt[i] == 0) m_unf[i] = 1; else m_cnt[i]--;
        end
`ifdef TRAFFIC_CONG_HYST_EN
        if (m_cnt[i] >= HI) m_cong[i] = 1;
        else if (m_cnt[i] <= LO) m_cong[i] = 0;
`else
        m_cong[i] = (m_cnt[i] >= HI);
`endif
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int dut_cnt(input int r);
    return int'(bus.count[r*CW +: CW]);
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < NR; i++) begin
        check($sformatf("mdl_count[%0d]", i), dut_cnt(i), m_cnt[i]);
        check($sformatf("mdl_cong[%0d]", i), int'(bus.congested[i]), int'(m_cong[i]));
        check($sformatf("mdl_ovf[%0d]", i), int'(bus.ovf_err[i]), int'(m_ovf[i]));
        check($sformatf("mdl_unf[%0d]", i), int'(bus.unf_err[i]), int'(m_unf[i]));
      end
      check("mdl_busiest_idx", int'(bus.busiest_idx), m_bidx);
      check("mdl_busiest_count", int'(bus.busiest_count), m_bcnt);
      check("mdl_total", int'(bus.total_count), m_total);
    end
  end

  // ---------------- drivers ----------------
  task automatic pulse(input logic [NR-1:0] s, input logic [NR-1:0] e);
    @(negedge clk);
    bus.pir_start = s;
    bus.pir_end   = e;
    repeat (2) @(negedge clk);
    bus.pir_start = '0;
    bus.pir_end   = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < NR; i++) begin
      check($sformatf("%s_count[%0d]", tag, i), dut_cnt(i), 0);
    end
    check({tag, "_cong"}, int'(bus.congested), 0);
    check({tag, "_ovf"}, int'(bus.ovf_err), 0);
    check({tag, "_unf"}, int'(bus.unf_err), 0);
    check({tag, "_bidx"}, int'(bus.busiest_idx), 0);
    check({tag, "_bcnt"}, int'(bus.busiest_count), 0);
    check({tag, "_total"}, int'(bus.total_count), 0);
  endtask

  initial begin
    int exp_c;
    bus.pir_start = '0;
    bus.pir_end   = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check_all_zero("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // single 2-cycle start pulse on road 0: latency pinned edge by edge
    bus.pir_start = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    check("lat_edge2_count0", dut_cnt(0), 0);
    bus.pir_start = '0;
    @(posedge clk); #1;
    check("lat_edge3_count0", dut_cnt(0), 1);
    check("lat_edge3_total", int'(bus.total_count), 0);
    @(posedge clk); #1;
    check("lat_edge4_bidx", int'(bus.busiest_idx), 0);
    check("lat_edge4_bcnt", int'(bus.busiest_count), 1);
    check("lat_edge4_total", int'(bus.total_count), 1);
    check("pin_model_count0", m_cnt[0], 1);

    // road 1: three in, one out
    repeat (3) pulse(4'b0010, 4'b0000);
    check("road1_up", dut_cnt(1), 3);
    pulse(4'b0000, 4'b0010);
    check("road1_down", dut_cnt(1), 2);
    check("road1_iso0", dut_cnt(0), 1);
    check("road1_iso2", dut_cnt(2), 0);
    check("road1_iso3", dut_cnt(3), 0);

    // road 3: underflow is sticky
    pulse(4'b1000, 4'b0000);
    pulse(4'b0000, 4'b1000);
    pulse(4'b0000, 4'b1000);
    check("road3_cnt0", dut_cnt(3), 0);
    check("road3_unf", int'(bus.unf_err[3]), 1);
    repeat (2) pulse(4'b1000, 4'b0000);
    check("road3_cnt2", dut_cnt(3), 2);
    check("road3_unf_sticky", int'(bus.unf_err[3]), 1);

    // road 0: coincident start/end at 5 and at 0
    repeat (4) pulse(4'b0001, 4'b0000);
    check("road0_at5", dut_cnt(0), 5);
    pulse(4'b0001, 4'b0001);
    check("road0_both_5", dut_cnt(0), 5);
    check("road0_both_5_ovf", int'(bus.ovf_err[0]), 0);
    check("road0_both_5_unf", int'(bus.unf_err[0]), 0);
    repeat (5) pulse(4'b0000, 4'b0001);
    check("road0_at0", dut_cnt(0), 0);
    pulse(4'b0001, 4'b0001);
    check("road0_both_0", dut_cnt(0), 0);
    check("road0_both_0_unf", int'(bus.unf_err[0]), 0);

    // road 2: ramp to saturation, then back down through the thresholds
    for (int k = 1; k <= 16; k++) begin
      pulse(4'b0100, 4'b0000);
      exp_c = (k > MAXC) ? MAXC : k;
      check($sformatf("road2_up_cnt_k%0d", k), dut_cnt(2), exp_c);
      check($sformatf("road2_up_cong_k%0d", k), int'(bus.congested[2]), (k >= HI) ? 1 : 0);
    end
    check("road2_ovf", int'(bus.ovf_err[2]), 1);
    check("pin_model_count2", m_cnt[2], 15);
    for (int c = 14; c >= 6; c--) begin
      pulse(4'b0000, 4'b0100);
      check($sformatf("road2_dn_cnt_c%0d", c), dut_cnt(2), c);
`ifdef TRAFFIC_CONG_HYST_EN
      check($sformatf("road2_dn_cong_c%0d", c), int'(bus.congested[2]), (c > LO) ? 1 : 0);
`else
      check($sformatf("road2_dn_cong_c%0d", c), int'(bus.congested[2]), (c >= HI) ? 1 : 0);
`endif
    end
    check("road2_ovf_sticky", int'(bus.ovf_err[2]), 1);

    // reset, then build {3,7,7,1}
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset2");
    reset = 1'b1;
    @(negedge clk);
    pulse(4'b1111, 4'b0000);
    repeat (2) pulse(4'b0111, 4'b0000);
    repeat (4) pulse(4'b0110, 4'b0000);
    check("mix_cnt0", dut_cnt(0), 3);
    check("mix_cnt1", dut_cnt(1), 7);
    check("mix_cnt2", dut_cnt(2), 7);
    check("mix_cnt3", dut_cnt(3), 1);
    check("mix_bidx", int'(bus.busiest_idx), 1);
    check("mix_bcnt", int'(bus.busiest_count), 7);
    check("mix_total", int'(bus.total_count), 18);
    check("pin_model_total", m_total, 18);

    // reset mid-pulse, keep sensors high across release
    @(negedge clk); bus.pir_start = 4'b1111;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midrst");
    @(negedge clk); reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) check($sformatf("held_cnt[%0d]", i), dut_cnt(i), 1);
    @(posedge clk); #1;
    check("held_total", int'(bus.total_count), 4);
    check("held_bidx", int'(bus.busiest_idx), 0);
    bus.pir_start = '0;
    repeat (4) @(negedge clk);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
